// File: rtl/decoder_pkg.sv
// Shared types and widths for the sequenced 3-to-8 decoder.
package decoder_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int CODE_W     = 3;
   localparam int ONEHOT_W   = 8;
   localparam int HOLD_CNT_W = 4;

endpackage

// File: rtl/decoder_3to8_seq_hold_counter.sv
// Down-counter that times how long one decoded code stays asserted.
// It saturates at zero so an idle block never wraps the counter.
module hold_counter
   import decoder_pkg::*;
#(
   parameter int HOLD_CYCLES = 3
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_dec,
   output logic o_zero
);

   logic [HOLD_CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= HOLD_CNT_W'(HOLD_CYCLES - 1);
      else if (i_dec && (r_cnt != '0))
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/decoder_3to8_seq.sv
// Decodes a 3-bit code to a one-hot held for HOLD_CYCLES cycles, with a
// single-entry pending buffer so back-to-back codes play out without gaps.
module decoder_3to8_seq
   import decoder_pkg::*;
#(
   parameter int HOLD_CYCLES = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [CODE_W-1:0]   in_code,
   output logic                in_ready,
   output logic [ONEHOT_W-1:0] out_onehot,
   output logic                out_valid,
   output logic                done
);

   state_t            r_state;
   logic [CODE_W-1:0] r_code;
   logic [CODE_W-1:0] r_buf_code;
   logic              r_buf_full;

   logic w_accept;
   logic w_active;
   logic w_zero;
   logic w_last;
   logic w_load;

   assign w_active = (r_state == ACTIVE);
   assign w_accept = in_valid && !r_buf_full;
   assign w_last   = w_active && w_zero;
   // A new hold window starts on entry from IDLE or on a gapless reload.
   assign w_load   = (!w_active && w_accept) || (w_last && (r_buf_full || w_accept));

   hold_counter #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_hold (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_load  (w_load),
      .i_dec   (w_active),
      .o_zero  (w_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_code     <= '0;
         r_buf_code <= '0;
         r_buf_full <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= ACTIVE;
                  r_code  <= in_code;
               end
            end
            ACTIVE: begin
               if (w_zero) begin
                  if (r_buf_full) begin
                     r_code     <= r_buf_code;
                     r_buf_full <= 1'b0;
                  end else if (w_accept) begin
                     r_code <= in_code;
                  end else begin
                     r_state <= IDLE;
                  end
               end else if (w_accept) begin
                  r_buf_code <= in_code;
                  r_buf_full <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready   = !r_buf_full;
   assign out_valid  = w_active;
   assign out_onehot = w_active ? (ONEHOT_W'(1) << r_code) : '0;
   assign done       = w_last;

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Directed bench for decoder_3to8_seq: HOLD_CYCLES=3 and HOLD_CYCLES=1 copies
// checked every cycle against a queue-based model plus literal expectations.
module tb_decoder_3to8_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       v3, v1;
   logic [2:0] c3, c1;
   logic       rd3, rd1, ov3, ov1, dn3, dn1;
   logic [7:0] oh3, oh1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decoder_3to8_seq #(.HOLD_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_code(c3),
      .in_ready(rd3), .out_onehot(oh3), .out_valid(ov3), .done(dn3)
   );

   decoder_3to8_seq #(.HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_code(c1),
      .in_ready(rd1), .out_onehot(oh1), .out_valid(ov1), .done(dn1)
   );

   // Model: accepted codes join a FIFO and are served in order, each for H cycles.
   bit         m_on = 1'b0;
   bit         m_act  [2];
   int         m_left [2];
   logic [2:0] m_code [2];
   logic [2:0] q0[$];
   logic [2:0] q1[$];

   task automatic model_step(input int k, input int h, input logic v, input logic [2:0] c);
      logic [2:0] q[$];
      bit acc;
      q = (k == 0) ? q0 : q1;
      if (!rst_n) begin
         m_act[k]  = 1'b0;
         m_left[k] = 0;
         q.delete();
      end else begin
         acc = v && (q.size() == 0);
         if (m_act[k]) begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) m_act[k] = 1'b0;
         end
         if (acc) q.push_back(c);
         if (!m_act[k] && q.size() > 0) begin
            m_code[k] = q.pop_front();
            m_act[k]  = 1'b1;
            m_left[k] = h;
         end
      end
      if (k == 0) q0 = q; else q1 = q;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [7:0] e_oh;
      e_oh = m_act[0] ? (8'd1 << m_code[0]) : 8'd0;
      chk("h3.onehot", 32'(oh3), 32'(e_oh));
      chk("h3.valid",  32'(ov3), 32'(m_act[0]));
      chk("h3.done",   32'(dn3), 32'(m_act[0] && m_left[0] == 1));
      chk("h3.ready",  32'(rd3), 32'(q0.size() == 0));
      e_oh = m_act[1] ? (8'd1 << m_code[1]) : 8'd0;
      chk("h1.onehot", 32'(oh1), 32'(e_oh));
      chk("h1.valid",  32'(ov1), 32'(m_act[1]));
      chk("h1.done",   32'(dn1), 32'(m_act[1] && m_left[1] == 1));
      chk("h1.ready",  32'(rd1), 32'(q1.size() == 0));
   endtask

   // One clock: advance the model on the edge, then check away from it.
   task automatic cyc();
      @(posedge clk);
      model_step(0, 3, v3, c3);
      model_step(1, 1, v1, c1);
      if (!rst_n) m_on = 1'b1;
      #2;
      if (m_on) compare_all();
   endtask

   initial begin
      rst_n = 1'b0; v3 = 1'b0; v1 = 1'b0; c3 = 3'd0; c1 = 3'd0;
      cyc(); cyc();
      rst_n = 1'b1;
      chk("rst.onehot", 32'(oh3), 32'h00);
      chk("rst.valid",  32'(ov3), 32'd0);
      chk("rst.done",   32'(dn3), 32'd0);
      chk("rst.ready",  32'(rd3), 32'd1);
      cyc();

      // Single code 5
      v3 = 1'b1; c3 = 3'd5;
      cyc(); v3 = 1'b0;
      chk("single.c1", 32'(oh3), 32'h20); chk("single.d1", 32'(dn3), 32'd0);
      cyc();
      chk("single.c2", 32'(oh3), 32'h20); chk("single.d2", 32'(dn3), 32'd0);
      cyc();
      chk("single.c3", 32'(oh3), 32'h20); chk("single.d3", 32'(dn3), 32'd1);
      cyc();
      chk("single.c4", 32'(oh3), 32'h00); chk("single.v4", 32'(ov3), 32'd0);

      // Buffered: 2 then 7
      v3 = 1'b1; c3 = 3'd2;
      cyc(); c3 = 3'd7;
      chk("buf.c1", 32'(oh3), 32'h04); chk("buf.r1", 32'(rd3), 32'd1);
      cyc(); v3 = 1'b0;
      chk("buf.c2", 32'(oh3), 32'h04); chk("buf.r2", 32'(rd3), 32'd0);
      cyc();
      chk("buf.c3", 32'(oh3), 32'h04); chk("buf.r3", 32'(rd3), 32'd0);
      chk("buf.d3", 32'(dn3), 32'd1);
      cyc();
      chk("buf.c4", 32'(oh3), 32'h80); chk("buf.d4", 32'(dn3), 32'd0);
      cyc();
      chk("buf.c5", 32'(oh3), 32'h80);
      cyc();
      chk("buf.c6", 32'(oh3), 32'h80); chk("buf.d6", 32'(dn3), 32'd1);
      cyc();
      chk("buf.c7", 32'(oh3), 32'h00);

      // Bypass: 1 then 0 on the last cycle
      v3 = 1'b1; c3 = 3'd1;
      cyc(); v3 = 1'b0;
      chk("byp.c1", 32'(oh3), 32'h02); chk("byp.r1", 32'(rd3), 32'd1);
      cyc();
      chk("byp.c2", 32'(oh3), 32'h02);
      cyc();
      chk("byp.c3", 32'(oh3), 32'h02); chk("byp.r3", 32'(rd3), 32'd1);
      v3 = 1'b1; c3 = 3'd0;
      cyc(); v3 = 1'b0;
      chk("byp.c4", 32'(oh3), 32'h01); chk("byp.r4", 32'(rd3), 32'd1);
      cyc();
      chk("byp.c5", 32'(oh3), 32'h01);
      cyc();
      chk("byp.c6", 32'(oh3), 32'h01); chk("byp.d6", 32'(dn3), 32'd1);
      cyc();
      chk("byp.c7", 32'(ov3), 32'd0);

      // Streaming on the HOLD_CYCLES=1 instance
      for (int i = 0; i < 8; i++) begin
         v1 = 1'b1; c1 = 3'(i);
         cyc();
         chk("stream.onehot", 32'(oh1), 32'(8'd1 << i));
         chk("stream.done",   32'(dn1), 32'd1);
         chk("stream.ready",  32'(rd1), 32'd1);
      end
      v1 = 1'b0;
      cyc();
      chk("stream.end", 32'(ov1), 32'd0);

      // Reset while active with 4 and buffered 6
      v3 = 1'b1; c3 = 3'd4;
      cyc(); c3 = 3'd6;
      cyc(); v3 = 1'b0;
      chk("rstop.full", 32'(rd3), 32'd0);
      rst_n = 1'b0;
      cyc(); rst_n = 1'b1;
      chk("rstop.onehot", 32'(oh3), 32'h00);
      chk("rstop.valid",  32'(ov3), 32'd0);
      chk("rstop.ready",  32'(rd3), 32'd1);
      chk("rstop.done",   32'(dn3), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("rstop.nodone", 32'(dn3), 32'd0);
         chk("rstop.idle",   32'(ov3), 32'd0);
      end

      // Accept presented during reset is dropped
      rst_n = 1'b0; v3 = 1'b1; c3 = 3'd3;
      cyc(); rst_n = 1'b1; v3 = 1'b0;
      chk("rstacc.valid", 32'(ov3), 32'd0);
      cyc();
      chk("rstacc.valid2", 32'(ov3), 32'd0);

      // Code present without valid
      c3 = 3'd3; v3 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("idlein.valid",  32'(ov3), 32'd0);
         chk("idlein.onehot", 32'(oh3), 32'h00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
